// File: rtl/modn_wrap_monitor.sv
// modn_wrap_monitor: checks a mod-N count stream, pulses on wraps and cascades them into a mod-M digit
module modn_wrap_monitor #(
   parameter int N      = 10,
   parameter int WIDTH  = 4,
   parameter int M      = 6,
   parameter int HWIDTH = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [WIDTH-1:0]  cnt_in,
   input  logic              err_clr,
   output logic              wrap_pulse,
   output logic [HWIDTH-1:0] high_cnt,
   output logic              high_tc,
   output logic              seq_err,
   output logic              locked
);
   typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;
   localparam logic [31:0]       N_U   = 32'(N);
   localparam logic [WIDTH-1:0]  LAST  = WIDTH'(N - 1);
   localparam logic [HWIDTH-1:0] HLAST = HWIDTH'(M - 1);
   state_t            state_q, state_d;
   logic [WIDTH-1:0]  prev_q, prev_d, nxt;
   logic [HWIDTH-1:0] high_q, high_d;
   logic              wrap_q, wrap_d, tc_q, tc_d, err_q, err_d, lock_q;
   logic              in_range;
   assign in_range   = 32'(cnt_in) < N_U;
   assign nxt        = (prev_q == LAST) ? '0 : prev_q + WIDTH'(1);
   assign wrap_pulse = wrap_q;
   assign high_cnt   = high_q;
   assign high_tc    = tc_q;
   assign seq_err    = err_q;
   assign locked     = lock_q;
   // next-state: err_clr in FAULT beats en; advance is tested before hold so N=1 wraps on every 0
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      high_d  = high_q;
      err_d   = err_q;
      wrap_d  = 1'b0;
      tc_d    = 1'b0;
      if (state_q == FAULT && err_clr) begin
         err_d   = 1'b0;
         state_d = SYNC;
      end else if (en) begin
         if (state_q == SYNC) begin
            prev_d  = in_range ? cnt_in : prev_q;
            err_d   = !in_range;
            state_d = in_range ? TRACK : FAULT;
         end else if (state_q == TRACK) begin
            if (cnt_in == nxt) begin
               prev_d = cnt_in;
               if (prev_q == LAST) begin
                  wrap_d = 1'b1;
                  tc_d   = high_q == HLAST;
                  high_d = (high_q == HLAST) ? '0 : high_q + HWIDTH'(1);
               end
            end else if (cnt_in != prev_q) begin
               err_d   = 1'b1;
               state_d = FAULT;
            end
         end else begin
            prev_d = cnt_in;
         end
      end
   end
   // state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SYNC;
         prev_q  <= '0;
         high_q  <= '0;
         wrap_q  <= 1'b0;
         tc_q    <= 1'b0;
         err_q   <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         high_q  <= high_d;
         wrap_q  <= wrap_d;
         tc_q    <= tc_d;
         err_q   <= err_d;
         lock_q  <= state_d == TRACK;
      end
   end
endmodule
